frame_buffer_reader: RTL and testbench
======================================

# frame_buffer_reader

Scanout side of the 1-bit double-buffered frame buffer. Runs the VGA raster and issues one read per active pixel into the frame buffer's display bank. Delivers the returned pixel with hsync/vsync aligned to it. Emits the `swap` pulse at the start of vertical blank, which hands the bank just scanned to the pattern/game writers.

## Interface
Parameters:
- `HOR_ACTIVE_PIXELS`, 640, visible pixels per line
- `HOR_FRONT_PORCH`, 16, pixel clocks
- `HOR_SYNC_PULSE`, 96, pixel clocks
- `HOR_BACK_PORCH`, 48, pixel clocks
- `VER_ACTIVE_PIXELS`, 480, visible lines
- `VER_FRONT_PORCH`, 10, lines
- `VER_SYNC_PULSE`, 2, lines
- `VER_BACK_PORCH`, 33, lines
- `SYNC_ACTIVE`, 1'b0, level of hsync/vsync during the sync pulse

Ports (reset `rst`, synchronous, active-high; clock `clk`):
- `clk`  in  1  system clock
- `rst`  in  1  synchronous active-high reset
- `ce`  in  1  pixel-clock enable; one raster position per `ce` tick
- `rd_en`  out  1  frame buffer read strobe, one `clk` wide
- `rd_addr`  out  `$clog2(HOR_ACTIVE_PIXELS*VER_ACTIVE_PIXELS)`  linear pixel address
- `rd_data`  in  1  pixel from the frame buffer; valid the `clk` after `rd_en` and held until the next `rd_en`
- `pixel`  out  1  pixel to the DAC/pin; forced 0 outside the active area
- `hsync`  out  1  horizontal sync
- `vsync`  out  1  vertical sync
- `swap`  out  1  one-`clk` pulse: bank exchange request

## Operation
- Two axis counters, `x` and `y`:
  - `x` counts 0..HOR_TOTAL-1, with HOR_TOTAL = sum of the four HOR_ parameters.
  - `y` counts 0..VER_TOTAL-1. It advances only when `x` wraps.
  - Both advance only on `ce`. With `ce` low, all state and outputs hold, except `rd_en` and `swap`, which are 0.
- Each axis is in one phase: ACTIVE, FRONT_PORCH, SYNC, or BACK_PORCH, in that order starting at counter value 0.
- A position is active when both axes are in ACTIVE.
- Address counter `addr`:
  - Increments by 1 on each `ce` tick at an active position.
  - Cleared to 0 on the `ce` tick where (`x`,`y`) = (HOR_TOTAL-1, VER_TOTAL-1).
  - No multiplier.
  - Range 0..HA*VA-1; it never wraps mid-frame.
- Stage 1, on a `ce` tick at position (`x`,`y`):
  - `rd_en` <= active.
  - `rd_addr` <= `addr`. This is updated only when active; otherwise it holds.
  - `active_d` <= active.
  - `hs_d` <= (h phase == SYNC).
  - `vs_d` <= (v phase == SYNC).
- Stage 2, on the next `ce` tick:
  - `pixel` <= `active_d` ? `rd_data` : 0.
  - `hsync` <= `hs_d` ? SYNC_ACTIVE : ~SYNC_ACTIVE.
  - `vsync` <= `vs_d` ? SYNC_ACTIVE : ~SYNC_ACTIVE.
- `swap` <= 1 on the `ce` tick at (`x`,`y`) = (0, VER_ACTIVE_PIXELS). This is the first front-porch line, and every read of the frame has already been issued. `swap` is 0 on every other cycle.
- Reset values:
  - `x` = `y` = `addr` = 0.
  - `rd_en` = 0, `rd_addr` = 0, `pixel` = 0, `swap` = 0.
  - `active_d` = 0, `hs_d` = `vs_d` = 0.
  - `hsync` = `vsync` = ~SYNC_ACTIVE.
- Reset mid-frame: the raster restarts at (0,0) on the first `ce` after `rst` deasserts. No `swap` is emitted for the aborted frame. The stale pipeline is discarded.

## Timing
- Raster position to pins: exactly 2 `ce` ticks. `pixel`, `hsync` and `vsync` are mutually aligned.
- `rd_en` is high for exactly the `clk` following an active `ce` tick. `rd_data` is sampled on the following `ce` tick. This needs `ce` spacing ≥ 1 `clk`, or `ce` tied high.
- With `ce` tied high: one read per `clk`, 1-`clk` memory latency, 2-`clk` total latency.
- `swap` fires once per frame, period HOR_TOTAL*VER_TOTAL `ce` ticks. The first `swap` after reset comes VER_ACTIVE_PIXELS*HOR_TOTAL ticks after the first `ce`.
- Width rules:
  - `x` is `$clog2(HOR_TOTAL)` bits and `y` is `$clog2(VER_TOTAL)` bits.
  - Phase boundary compares are against localparam sums, not truncated constants.

## Structure
- Shared package `frame_buffer_pkg` holds:
  - `phase_t` enum (ACTIVE, FRONT_PORCH, SYNC, BACK_PORCH).
  - A function computing the total from four phase lengths.
  - The address-width localparam formula, also used by the writers.
- Sub-module `vga_axis_counter`, instantiated twice (horizontal and vertical):
  - Parameters: ACTIVE, FRONT, SYNC, BACK.
  - Inputs: `clk`, `rst`, `en`.
  - Outputs: `count`, `phase`, `wrap` (combinational, high on the last count).
  - The vertical instance's `en` = `ce` & horizontal `wrap`.
- Top level holds the address counter, the two pipeline stages and the `swap` logic.

## Test plan
Small raster for all cases: HA=4, HFP=1, HS=2, HBP=1 (HT=8); VA=3, VFP=1, VS=1, VBP=1 (VT=6); SYNC_ACTIVE=0; `ce`=1.
- Reset then run 1 frame:
  - `rd_en` is high exactly 12 times, with `rd_addr` sequence 0..11.
  - `swap` is high once, at `clk` 25 after reset release (3*8 + 1).
- Memory model returns `rd_addr[0]`:
  - `pixel` is 0,1,0,1 on each active line, two clocks after each read.
  - `pixel` is 0 during all blanking.
- Sync check:
  - `hsync` is low for exactly 2 clocks per line, starting 2 clocks after `x` = 5.
  - `vsync` is low for exactly 8 clocks per frame.
- `ce` one clock in three:
  - Same address sequence and same `pixel`/sync pattern, in `ce` units.
  - `rd_en` and `swap` are 1-`clk` pulses.
- `rst` asserted at `x`=2, `y`=1:
  - The next frame restarts at `rd_addr` 0.
  - No `swap` until a full 3 active lines have been read.
  - `hsync` and `vsync` are 1 during reset.
- 3 consecutive frames: `swap` period is exactly 48 clocks, and the `rd_addr` sequence restarts at 0 each frame.

Source files
------------

// File: rtl/frame_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : frame_buffer_pkg
//  Description : Shared types and helpers for the 1-bit double-buffered frame
//                buffer: raster phase encoding, phase-length totals and the
//                linear pixel address width used by readers and writers.
//  Revision    : 1.0 - initial release
// ============================================================================
package frame_buffer_pkg;

    // Raster phase of one axis, in the order the counter walks through them
    typedef enum logic [1:0] {
        ACTIVE      = 2'd0,
        FRONT_PORCH = 2'd1,
        SYNC        = 2'd2,
        BACK_PORCH  = 2'd3
    } phase_t;

    // Total counter span of one axis
    function automatic int phase_total(input int active_len, input int front_len,
                                       input int sync_len, input int back_len);
        return active_len + front_len + sync_len + back_len;
    endfunction

    // Width of a linear pixel address covering the whole visible area
    function automatic int fb_addr_width(input int hor_active, input int ver_active);
        return $clog2(hor_active * ver_active);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`default_nettype none
// ============================================================================
//  Module      : vga_axis_counter
//  Description : One raster axis: a wrapping position counter with phase
//                decode (active / front porch / sync / back porch) and a
//                combinational wrap flag on the last count.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_axis_counter #(
    parameter int  ACTIVE = 640,
    parameter int  FRONT  = 16,
    parameter int  SYNC   = 96,
    parameter int  BACK   = 48,
    localparam int TOTAL  = frame_buffer_pkg::phase_total(ACTIVE, FRONT, SYNC, BACK),
    localparam int CW     = $clog2(TOTAL)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    output logic [CW-1:0]             count,
    output frame_buffer_pkg::phase_t  phase,
    output logic                      wrap
);

    // Phase boundaries kept as full-width integer sums
    localparam int END_ACTIVE = ACTIVE;
    localparam int END_FRONT  = ACTIVE + FRONT;
    localparam int END_SYNC   = ACTIVE + FRONT + SYNC;
    localparam logic [CW-1:0] LAST_COUNT = CW'(TOTAL - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign count = count_q;
    assign wrap  = (count_q == LAST_COUNT);

    // Next position: advance on enable, wrap back to zero after the last count
    always_comb begin
        count_d = count_q;
        if (rst) begin
            count_d = '0;
        end else if (en) begin
            count_d = wrap ? '0 : count_q + 1'b1;
        end
    end

    // Position register
    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    // Phase decode from the current position
    always_comb begin
        phase = frame_buffer_pkg::BACK_PORCH;
        if (int'(count_q) < END_ACTIVE) begin
            phase = frame_buffer_pkg::ACTIVE;
        end else if (int'(count_q) < END_FRONT) begin
            phase = frame_buffer_pkg::FRONT_PORCH;
        end else if (int'(count_q) < END_SYNC) begin
            phase = frame_buffer_pkg::SYNC;
        end
    end

endmodule
`default_nettype wire

// File: rtl/frame_buffer_reader.sv
`default_nettype none
// ============================================================================
//  Module      : frame_buffer_reader
//  Description : Scanout side of the frame buffer. Runs the VGA raster, issues
//                one read per active pixel, aligns the returned pixel with
//                hsync/vsync and requests a bank swap at vertical blank.
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_buffer_reader
    import frame_buffer_pkg::*;
#(
    parameter int   HOR_ACTIVE_PIXELS = 640,
    parameter int   HOR_FRONT_PORCH   = 16,
    parameter int   HOR_SYNC_PULSE    = 96,
    parameter int   HOR_BACK_PORCH    = 48,
    parameter int   VER_ACTIVE_PIXELS = 480,
    parameter int   VER_FRONT_PORCH   = 10,
    parameter int   VER_SYNC_PULSE    = 2,
    parameter int   VER_BACK_PORCH    = 33,
    parameter logic SYNC_ACTIVE       = 1'b0,
    localparam int  ADDR_W = fb_addr_width(HOR_ACTIVE_PIXELS, VER_ACTIVE_PIXELS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_data,
    output logic              pixel,
    output logic              hsync,
    output logic              vsync,
    output logic              swap
);

    localparam int HOR_TOTAL = phase_total(HOR_ACTIVE_PIXELS, HOR_FRONT_PORCH,
                                           HOR_SYNC_PULSE, HOR_BACK_PORCH);
    localparam int VER_TOTAL = phase_total(VER_ACTIVE_PIXELS, VER_FRONT_PORCH,
                                           VER_SYNC_PULSE, VER_BACK_PORCH);
    localparam int XW = $clog2(HOR_TOTAL);
    localparam int YW = $clog2(VER_TOTAL);

    logic [XW-1:0] x;
    logic [YW-1:0] y;
    phase_t        h_phase;
    phase_t        v_phase;
    logic          h_wrap;
    logic          v_wrap;
    logic          v_en;
    logic          active;
    logic          frame_end;
    logic          blank_start;

    // Vertical axis steps once per completed line
    assign v_en = ce & h_wrap;

    vga_axis_counter #(
        .ACTIVE (HOR_ACTIVE_PIXELS),
        .FRONT  (HOR_FRONT_PORCH),
        .SYNC   (HOR_SYNC_PULSE),
        .BACK   (HOR_BACK_PORCH)
    ) u_h_axis (
        .clk   (clk),
        .rst   (rst),
        .en    (ce),
        .count (x),
        .phase (h_phase),
        .wrap  (h_wrap)
    );

    vga_axis_counter #(
        .ACTIVE (VER_ACTIVE_PIXELS),
        .FRONT  (VER_FRONT_PORCH),
        .SYNC   (VER_SYNC_PULSE),
        .BACK   (VER_BACK_PORCH)
    ) u_v_axis (
        .clk   (clk),
        .rst   (rst),
        .en    (v_en),
        .count (y),
        .phase (v_phase),
        .wrap  (v_wrap)
    );

    assign active      = (h_phase == ACTIVE) && (v_phase == ACTIVE);
    assign frame_end   = h_wrap & v_wrap;
    // First position of the first front-porch line: every read is issued
    assign blank_start = (x == '0) && (int'(y) == VER_ACTIVE_PIXELS);

    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic              rd_en_q,     rd_en_d;
    logic [ADDR_W-1:0] rd_addr_q,   rd_addr_d;
    logic              active_s1_q, active_s1_d;
    logic              hs_s1_q,     hs_s1_d;
    logic              vs_s1_q,     vs_s1_d;
    logic              pixel_q,     pixel_d;
    logic              hsync_q,     hsync_d;
    logic              vsync_q,     vsync_d;
    logic              swap_q,      swap_d;

    // Address counter, read issue stage, output alignment stage and swap pulse
    always_comb begin
        addr_d      = addr_q;
        rd_en_d     = 1'b0;
        rd_addr_d   = rd_addr_q;
        active_s1_d = active_s1_q;
        hs_s1_d     = hs_s1_q;
        vs_s1_d     = vs_s1_q;
        pixel_d     = pixel_q;
        hsync_d     = hsync_q;
        vsync_d     = vsync_q;
        swap_d      = 1'b0;
        if (rst) begin
            addr_d      = '0;
            rd_addr_d   = '0;
            active_s1_d = 1'b0;
            hs_s1_d     = 1'b0;
            vs_s1_d     = 1'b0;
            pixel_d     = 1'b0;
            hsync_d     = ~SYNC_ACTIVE;
            vsync_d     = ~SYNC_ACTIVE;
        end else if (ce) begin
            if (active) begin
                addr_d    = addr_q + 1'b1;
                rd_addr_d = addr_q;
            end
            if (frame_end) begin
                addr_d = '0;
            end
            rd_en_d     = active;
            active_s1_d = active;
            hs_s1_d     = (h_phase == SYNC);
            vs_s1_d     = (v_phase == SYNC);
            pixel_d     = active_s1_q ? rd_data : 1'b0;
            hsync_d     = hs_s1_q ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vsync_d     = vs_s1_q ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            swap_d      = blank_start;
        end
    end

    // Pipeline and address registers
    always_ff @(posedge clk) begin
        addr_q      <= addr_d;
        rd_en_q     <= rd_en_d;
        rd_addr_q   <= rd_addr_d;
        active_s1_q <= active_s1_d;
        hs_s1_q     <= hs_s1_d;
        vs_s1_q     <= vs_s1_d;
        pixel_q     <= pixel_d;
        hsync_q     <= hsync_d;
        vsync_q     <= vsync_d;
        swap_q      <= swap_d;
    end

    assign rd_en   = rd_en_q;
    assign rd_addr = rd_addr_q;
    assign pixel   = pixel_q;
    assign hsync   = hsync_q;
    assign vsync   = vsync_q;
    assign swap    = swap_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_buffer_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frame_buffer_reader
//  Description : Directed self-checking bench for frame_buffer_reader on an
//                8x6 raster (4x3 visible, active-low sync).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_buffer_reader;

    localparam int HT    = 8;
    localparam int FRAME = 48;
    localparam int NPIX  = 12;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          ce;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          rd_data;
    logic          pixel;
    logic          hsync;
    logic          vsync;
    logic          swap;

    int total_cnt = 0;
    int bad_cnt   = 0;
    int tick, cyc, rd_cnt, swap_cnt, hs_low_cnt, vs_low_cnt;
    int first_swap_cyc, last_swap_cyc, swap_period_exp;

    always #5 clk = ~clk;

    // Memory model: each pixel equals bit 0 of its address
    assign rd_data = rd_addr[0];

    frame_buffer_reader #(
        .HOR_ACTIVE_PIXELS (4),
        .HOR_FRONT_PORCH   (1),
        .HOR_SYNC_PULSE    (2),
        .HOR_BACK_PORCH    (1),
        .VER_ACTIVE_PIXELS (3),
        .VER_FRONT_PORCH   (1),
        .VER_SYNC_PULSE    (1),
        .VER_BACK_PORCH    (1),
        .SYNC_ACTIVE       (1'b0)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ce      (ce),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .pixel   (pixel),
        .hsync   (hsync),
        .vsync   (vsync),
        .swap    (swap)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d tick %0d)", tag, obs, exp, cyc, tick);
        end
    endtask

    // Visible area is x 0..3 on lines 0..2
    function automatic logic is_act(input int p);
        return ((p % HT) < 4) && ((p / HT) < 3);
    endfunction

    // One clk: drive, wait for the edge, sample on the falling edge and check
    task automatic step(input logic ce_val, input logic rst_val);
        int   p1, p2;
        logic e_rd, e_pix, e_hs, e_vs, e_sw;
        rst = rst_val;
        ce  = ce_val;
        @(posedge clk);
        if (!rst_val) begin
            cyc++;
            if (ce_val) tick++;
        end
        @(negedge clk);
        if (rst_val) begin
            check("rst_rd_en", rd_en, 0);
            check("rst_rd_addr", rd_addr, 0);
            check("rst_pixel", pixel, 0);
            check("rst_hsync", hsync, 1);
            check("rst_vsync", vsync, 1);
            check("rst_swap", swap, 0);
        end else begin
            p1    = (tick >= 1) ? (tick - 1) % FRAME : 0;
            p2    = (tick >= 2) ? (tick - 2) % FRAME : 0;
            e_rd  = ce_val && (tick >= 1) && is_act(p1);
            e_sw  = ce_val && (tick >= 1) && (p1 == 24);
            e_pix = (tick >= 2) && is_act(p2) && ((p2 % HT) % 2 == 1);
            e_hs  = !((tick >= 2) && ((p2 % HT) == 5 || (p2 % HT) == 6));
            e_vs  = !((tick >= 2) && ((p2 / HT) == 4));
            check("rd_en", rd_en, e_rd);
            if (e_rd) check("rd_addr", rd_addr, (p1 / HT) * 4 + (p1 % HT));
            check("pixel", pixel, e_pix);
            check("hsync", hsync, e_hs);
            check("vsync", vsync, e_vs);
            check("swap", swap, e_sw);
            if (rd_en === 1'b1) begin
                check("rd_addr_seq", rd_addr, rd_cnt % NPIX);
                rd_cnt++;
            end
            if (hsync === 1'b0) hs_low_cnt++;
            if (vsync === 1'b0) vs_low_cnt++;
            if (swap === 1'b1) begin
                if (swap_cnt == 0) first_swap_cyc = cyc;
                else check("swap_period", cyc - last_swap_cyc, swap_period_exp);
                last_swap_cyc = cyc;
                swap_cnt++;
            end
        end
    endtask

    task automatic do_reset(input int ncyc);
        for (int i = 0; i < ncyc; i++) step(1'b1, 1'b1);
        tick = 0; cyc = 0; rd_cnt = 0; swap_cnt = 0;
        hs_low_cnt = 0; vs_low_cnt = 0;
        first_swap_cyc = -1; last_swap_cyc = -1;
    endtask

    initial begin
        rst = 1'b1;
        ce  = 1'b0;

        // Three back-to-back frames with ce tied high
        do_reset(3);
        swap_period_exp = FRAME;
        for (int i = 0; i < FRAME; i++) step(1'b1, 1'b0);
        check("f1_rd_en_count", rd_cnt, NPIX);
        check("f1_swap_count", swap_cnt, 1);
        check("f1_swap_clk", first_swap_cyc, 25);
        check("f1_vsync_low_clks", vs_low_cnt, 8);
        for (int i = 0; i < 2 * FRAME; i++) step(1'b1, 1'b0);
        check("f3_rd_en_count", rd_cnt, 3 * NPIX);
        check("f3_swap_count", swap_cnt, 3);
        check("f3_hsync_low_clks", hs_low_cnt, 36);
        check("f3_vsync_low_clks", vs_low_cnt, 24);

        // ce one clock in three
        do_reset(2);
        swap_period_exp = 3 * FRAME;
        for (int i = 0; i < FRAME; i++) begin
            step(1'b1, 1'b0);
            step(1'b0, 1'b0);
            step(1'b0, 1'b0);
        end
        check("ce3_rd_en_count", rd_cnt, NPIX);
        check("ce3_swap_count", swap_cnt, 1);
        check("ce3_swap_clk", first_swap_cyc, 73);
        check("ce3_vsync_low_clks", vs_low_cnt, 24);

        // Reset in the middle of line 1 at x=2, then a clean frame
        do_reset(2);
        swap_period_exp = FRAME;
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
        check("pre_abort_rd_count", rd_cnt, 6);
        check("pre_abort_swap_count", swap_cnt, 0);
        do_reset(3);
        for (int i = 0; i < FRAME; i++) step(1'b1, 1'b0);
        check("post_abort_rd_count", rd_cnt, NPIX);
        check("post_abort_swap_count", swap_cnt, 1);
        check("post_abort_swap_clk", first_swap_cyc, 25);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
`default_nettype wire
